audio_level_meter: RTL and testbench
====================================

// Module: audio_level_meter
// PURPOSE
//  Parametrised microphone volume meter, successor to the fixed 12-bit/9-LED meter.
//  - Takes a sample stream qualified by a strobe and removes the mic DC offset.
//  - Tracks the peak magnitude over a programmable window and quantises it to a level.
//  - Drives the LED bar graph and a one-digit 7-seg.
//  - Adds a peak-hold mode with timed decay.
//  Sits between the mic ADC front end (20 kHz strobe) and the board LED/7-seg outputs.
// PARAMETERS
//  SAMPLE_W     12    ADC sample width, unsigned
//  DC_OFFSET    2048  sample code for silence; subtracted before magnitude
//  WINDOW       4000  valid samples per measurement window (>=2)
//  LEVELS       9     number of bar LEDs / max level (1..15)
//  HOLD_WINDOWS 5     windows a held level persists before decaying by 1
// PORTS
//  clock         in   1              system clock
//  resetn        in   1              synchronous reset, active-low
//  sample_valid  in   1              one-cycle strobe: sample is valid
//  sample        in   SAMPLE_W       raw ADC code
//  hold_en       in   1              1 = peak-hold/decay mode, 0 = instantaneous
//  level         out  LVL_W          displayed level 0..LEVELS; LVL_W = $clog2(LEVELS+1)
//  led           out  LEVELS         thermometer bar: led[i] = (level > i)
//  seg           out  7              active-low segments {g,f,e,d,c,b,a}, hex digit of level
//  an            out  4              active-low anodes; 4'b1110 (rightmost digit only)
//  update        out  1              one-cycle pulse when outputs are refreshed
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): level=0, led=0, seg=7'b1000000 ("0"), an=4'b1110, update=0.
//    Internal state is also cleared: sample count, window peak, held level, hold timer.
//    Reset mid-window discards the partial window.
//  - Magnitude: mag = |sample - DC_OFFSET|, computed at SAMPLE_W+1 bits.
//    Saturate to 2^(SAMPLE_W-1)-1.
//  - Samples are used only when sample_valid=1; the count wraps at WINDOW.
//  - Window peak: peak_nxt = max(peak, mag). The current sample counts in the same cycle.
//  - Window end: on the sample_valid cycle where count == WINDOW-1, the final sample is
//    included via peak_nxt. Next cycle: outputs update, update=1, peak and count restart at 0.
//  - Latency: outputs reflect the window one clock after its last valid sample.
//  - Quantiser: STEP = 2^(SAMPLE_W-1)/LEVELS, integer division.
//    new_lvl = number of k in 1..LEVELS with peak_nxt >= k*STEP.
//  - hold_en=0: level = new_lvl; the hold register tracks new_lvl and the hold timer = 0.
//  - hold_en=1, evaluated at each window end:
//    - If new_lvl >= held: held = new_lvl and the timer resets to 0.
//    - Else, if timer == HOLD_WINDOWS-1: held = held-1 (floor 0) and the timer resets to 0.
//    - Otherwise the timer increments by 1.
//    - level = held.
//  - Toggling hold_en takes effect at the next window end only; no output changes between windows.
//  - A sample_valid on the update cycle belongs to the new window, as sample 0.
//  - seg encodes 0..F. Levels above 9 show A..F.
//  - an is constant after reset.
// STRUCTURE
//  - Shared package audio_pkg:
//    - 7-seg hex lookup function
//    - LVL_W helper
//    - SEG_BLANK / AN_DIGIT0 constants
//  - Sub-module level_quantiser (combinational): peak -> new_lvl, parametrised by SAMPLE_W and LEVELS.
//  - Top module contains:
//    - window counter
//    - peak register
//    - hold/decay register and timer
//    - output registers
// TESTING (SAMPLE_W=12, DC_OFFSET=2048, LEVELS=9, STEP=227, WINDOW=4, HOLD_WINDOWS=2)
//  1. Reset: hold resetn=0 for 3 clocks, with strobes and sample=4095 applied -> level=0,
//     led=0, seg=7'b1000000, an=4'b1110, no update pulse.
//  2. Window of 2048,2548,2100,2048 with hold_en=0 -> mag peak 500, level=2,
//     led=9'b000000011, seg=7'b0100100, update high 1 clock after 4th strobe.
//  3. Last-sample peak: 2048,2048,2048,0 -> mag saturates 2047, level=9, led=9'h1FF,
//     seg=7'b0010000.
//  4. Hold/decay: hold_en=1, one level-9 window, then silent windows -> level 9,9,8,8,7.
//     A level-5 window mid-decay does not raise level; an equal level resets the timer.
//  5. Gapped strobes: sample_valid every 3rd clock plus idle gaps -> only 4 valid samples close
//     a window; update is spaced accordingly.
//  6. Reset mid-window after 2 samples of 4095: release -> next window of silence gives
//     level=0 (the old peak is not retained).

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio level meter: 7-seg hex encoding,
// level-width helper and display constants.
package audio_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_DIGIT0 = 4'b1110;

  function automatic int lvl_w(input int levels);
    return $clog2(levels + 1);
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/level_quantiser.sv
// Maps a window peak magnitude to a bar level: count of thresholds k*STEP
// (k = 1..LEVELS) that the peak meets or exceeds.
module level_quantiser
  import audio_pkg::*;
#(
  parameter  int SAMPLE_W = 12,
  parameter  int LEVELS   = 9,
  localparam int LVL_W    = lvl_w(LEVELS)
) (
  input  logic [SAMPLE_W-2:0] peak,
  output logic [LVL_W-1:0]    lvl
);

  localparam int STEP = (2 ** (SAMPLE_W - 1)) / LEVELS;

  always_comb begin
    lvl = '0;
    for (int k = 1; k <= LEVELS; k++)
      if (int'(peak) >= k * STEP) lvl = lvl + LVL_W'(1);
  end

endmodule

// File: rtl/audio_level_meter.sv
// Microphone level meter: DC removal, windowed peak detect, quantised level with
// optional peak-hold/decay, driving an LED bar and a single 7-seg digit.
module audio_level_meter
  import audio_pkg::*;
#(
  parameter  int SAMPLE_W     = 12,
  parameter  int DC_OFFSET    = 2048,
  parameter  int WINDOW       = 4000,
  parameter  int LEVELS       = 9,
  parameter  int HOLD_WINDOWS = 5,
  localparam int LVL_W        = lvl_w(LEVELS)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                hold_en,
  output logic [LVL_W-1:0]    level,
  output logic [LEVELS-1:0]   led,
  output logic [6:0]          seg,
  output logic [3:0]          an,
  output logic                update
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam int TMR_W = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;
  localparam logic [SAMPLE_W:0] MAG_MAX = (SAMPLE_W + 1)'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic [SAMPLE_W:0] DC_CODE = (SAMPLE_W + 1)'(DC_OFFSET);

  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-2:0] peak, peak_nxt, mag;
  logic [LVL_W-1:0]    held, held_nxt, new_lvl;
  logic [TMR_W-1:0]    tmr, tmr_nxt;
  logic [LEVELS-1:0]   led_nxt;
  logic signed [SAMPLE_W:0] diff;
  logic [SAMPLE_W:0]   absd;
  logic                win_end;

  // One extra bit so the offset subtraction can go negative without wrapping
  always_comb begin
    diff = $signed({1'b0, sample}) - $signed(DC_CODE);
    absd = diff[SAMPLE_W] ? unsigned'(-diff) : unsigned'(diff);
    mag  = (absd > MAG_MAX) ? MAG_MAX[SAMPLE_W-2:0] : absd[SAMPLE_W-2:0];
  end

  assign win_end  = sample_valid && (cnt == CNT_W'(WINDOW - 1));
  assign peak_nxt = (sample_valid && mag > peak) ? mag : peak;

  level_quantiser #(
    .SAMPLE_W(SAMPLE_W),
    .LEVELS  (LEVELS)
  ) u_quant (
    .peak(peak_nxt),
    .lvl (new_lvl)
  );

  // Hold register doubles as the displayed level; in bypass mode it simply tracks
  always_comb begin
    held_nxt = new_lvl;
    tmr_nxt  = '0;
    if (hold_en && new_lvl < held) begin
      if (tmr == TMR_W'(HOLD_WINDOWS - 1))
        held_nxt = (held == '0) ? '0 : held - LVL_W'(1);
      else begin
        held_nxt = held;
        tmr_nxt  = tmr + TMR_W'(1);
      end
    end
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < LEVELS; i++) led_nxt[i] = (int'(held_nxt) > i);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt    <= '0;
      peak   <= '0;
      held   <= '0;
      tmr    <= '0;
      level  <= '0;
      led    <= '0;
      seg    <= hex7seg(4'h0);
      an     <= AN_DIGIT0;
      update <= 1'b0;
    end else begin
      an     <= AN_DIGIT0;
      update <= win_end;
      if (win_end) begin
        cnt   <= '0;
        peak  <= '0;
        held  <= held_nxt;
        tmr   <= tmr_nxt;
        level <= held_nxt;
        led   <= led_nxt;
        seg   <= hex7seg(4'(held_nxt));
      end else if (sample_valid) begin
        cnt  <= cnt + CNT_W'(1);
        peak <= peak_nxt;
      end
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// Self-checking bench for audio_level_meter: directed scenarios plus random
// traffic compared every cycle against a queue-based window model.
module tb_audio_level_meter;

  localparam int WIN  = 4;
  localparam int LEV  = 9;
  localparam int HW   = 2;
  localparam int STEP = 2048 / LEV;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic        hold_en = 1'b0;
  logic [3:0]  level;
  logic [8:0]  led;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        update;

  audio_level_meter #(
    .SAMPLE_W    (12),
    .DC_OFFSET   (2048),
    .WINDOW      (WIN),
    .LEVELS      (LEV),
    .HOLD_WINDOWS(HW)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .sample_valid(sample_valid),
    .sample      (sample),
    .hold_en     (hold_en),
    .level       (level),
    .led         (led),
    .seg         (seg),
    .an          (an),
    .update      (update)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int   mq[$];
  int   m_level = 0, m_held = 0, m_tmr = 0;
  bit   m_update = 0;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic int mag_of(input int s);
    int d;
    d = s - 2048;
    if (d < 0) d = -d;
    if (d > 2047) d = 2047;
    return d;
  endfunction

  task automatic model_clock(input bit v, input int s, input bit h, input bit rn);
    int pk, nl;
    m_update = 0;
    if (!rn) begin
      mq.delete();
      m_level = 0; m_held = 0; m_tmr = 0;
    end else if (v) begin
      mq.push_back(mag_of(s));
      if (mq.size() == WIN) begin
        pk = 0;
        foreach (mq[i]) if (mq[i] > pk) pk = mq[i];
        nl = pk / STEP;
        if (nl > LEV) nl = LEV;
        if (!h || nl >= m_held) begin
          m_held = nl; m_tmr = 0;
        end else if (m_tmr == HW - 1) begin
          m_held = (m_held > 0) ? m_held - 1 : 0; m_tmr = 0;
        end else
          m_tmr++;
        m_level  = m_held;
        m_update = 1;
        mq.delete();
      end
    end
  endtask

  task automatic step(input bit v, input int s, input bit h, input bit rn);
    sample_valid = v; sample = 12'(s); hold_en = h; resetn = rn;
    @(posedge clock);
    model_clock(v, s, h, rn);
    #1;
    check_eq("level",  32'(level),  32'(m_level));
    check_eq("led",    32'(led),    32'((1 << m_level) - 1));
    check_eq("seg",    32'(seg),    32'(seg_tab[m_level]));
    check_eq("an",     32'(an),     32'(4'b1110));
    check_eq("update", 32'(update), 32'(m_update));
  endtask

  task automatic run_window(input int s0, s1, s2, s3, input bit h);
    step(1, s0, h, 1); step(1, s1, h, 1); step(1, s2, h, 1); step(1, s3, h, 1);
  endtask

  int exp_seq[5] = '{9, 9, 8, 8, 7};
  int ups, first_up, second_up;

  initial begin
    // Reset with live strobes of full-scale samples
    for (int i = 0; i < 3; i++) step(1, 4095, 0, 0);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_seg", 32'(seg), 32'(7'b1000000));
    check_eq("rst_update", 32'(update), 0);

    // Basic window, update lands right after 4th strobe
    step(1, 2048, 0, 1); step(1, 2548, 0, 1); step(1, 2100, 0, 1);
    check_eq("t2_no_update_early", 32'(update), 0);
    step(1, 2048, 0, 1);
    check_eq("t2_update", 32'(update), 1);
    check_eq("t2_level", 32'(level), 2);
    check_eq("t2_led", 32'(led), 32'(9'b000000011));
    check_eq("t2_seg", 32'(seg), 32'(7'b0100100));
    step(0, 0, 0, 1);
    check_eq("t2_update_pulse", 32'(update), 0);

    // Saturating final sample
    run_window(2048, 2048, 2048, 0, 0);
    check_eq("t3_level", 32'(level), 9);
    check_eq("t3_led", 32'(led), 32'(9'h1FF));
    check_eq("t3_seg", 32'(seg), 32'(7'b0010000));

    // Hold and decay
    run_window(4095, 2048, 2048, 2048, 1);
    check_eq("t4_w0", 32'(level), 32'(exp_seq[0]));
    for (int w = 1; w < 5; w++) begin
      run_window(2048, 2048, 2048, 2048, 1);
      check_eq($sformatf("t4_w%0d", w), 32'(level), 32'(exp_seq[w]));
    end
    run_window(2048, 3248, 2048, 2048, 1);
    check_eq("t4_low_window", 32'(level), 7);
    run_window(2048, 2048, 3648, 2048, 1);
    check_eq("t4_equal_window", 32'(level), 7);
    run_window(2048, 2048, 2048, 2048, 1);
    check_eq("t4_timer_reset", 32'(level), 7);
    run_window(2048, 2048, 2048, 2048, 1);
    check_eq("t4_decay_after_reset", 32'(level), 6);

    // Gapped strobes every third clock
    ups = 0; first_up = -1; second_up = -1;
    for (int c = 0; c < 27; c++) begin
      if (c % 3 == 0 && c < 24) step(1, 2048 + c * 40, 0, 1);
      else step(0, 4095, 0, 1);
      if (update) begin
        ups++;
        if (first_up < 0) first_up = c; else second_up = c;
      end
    end
    check_eq("t5_updates", 32'(ups), 2);
    check_eq("t5_spacing", 32'(second_up - first_up), 12);

    // Reset mid-window discards partial peak
    step(1, 4095, 0, 1); step(1, 4095, 0, 1);
    step(1, 4095, 0, 0);
    run_window(2048, 2048, 2048, 2048, 0);
    check_eq("t6_level", 32'(level), 0);
    check_eq("t6_update", 32'(update), 1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      automatic bit v  = ($urandom_range(0, 1) == 1);
      automatic int s  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                                   : 2048 + int'($urandom_range(0, 600)) - 300;
      automatic bit h  = (i / 80) % 2 == 1;
      automatic bit rn = ($urandom_range(0, 99) != 0);
      step(v, s, h, rn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
